// File: rtl/sc_resolver.sv
// Store-conditional resolver for the MEM stage.
// Decides whether an SC proceeds from the atomic bit, word alignment and an
// optional link-address check. A passing SC drives the data-memory write
// handshake and stalls the pipeline until the write is acknowledged. Every
// resolved SC ends with a one-cycle atomic-bit clear.
// Optional feature: define LINK_ADDR_CHECK_EN to build the link register and
// store snooping. When it is undefined, ll_i and st_i are unused.
module sc_resolver #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_flg_i,
  input  logic              llbit_i,
  input  logic              ll_i,
  input  logic              sc_i,
  input  logic              st_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              stall_o,
  output logic              sc_done_o,
  output logic [DATA_W-1:0] sc_result_o,
  output logic              llbit_we_o,
  output logic              llbit_o
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              sc_done_q, sc_done_d;
  logic              llbit_we_q, llbit_we_d;
  logic              result_q, result_d;
  // Remembers a flush seen at any point while the write was outstanding.
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic sc_go;
  logic sc_pass;

  assign sc_go = (state_q == StIdle) && sc_i && !exc_flg_i;

`ifdef LINK_ADDR_CHECK_EN
  logic [ADDR_W-3:0] link_addr_q, link_addr_d;
  logic              link_vld_q, link_vld_d;
  logic              link_hit;

  assign link_hit = link_vld_q && (addr_i[ADDR_W-1:2] == link_addr_q);
  assign sc_pass  = llbit_i && (addr_i[1:0] == 2'b00) && link_hit;

  // Link register update; a flush overrides everything, LL beats a snooped store.
  always_comb begin
    link_addr_d = link_addr_q;
    link_vld_d  = link_vld_q;
    if (st_i && (addr_i[ADDR_W-1:2] == link_addr_q)) begin
      link_vld_d = 1'b0;
    end
    if (sc_go) begin
      link_vld_d = 1'b0;
    end
    if (ll_i) begin
      link_addr_d = addr_i[ADDR_W-1:2];
      link_vld_d  = 1'b1;
    end
    if (exc_flg_i) begin
      link_vld_d = 1'b0;
    end
  end

  // Link register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_addr_q <= '0;
      link_vld_q  <= 1'b0;
    end else begin
      link_addr_q <= link_addr_d;
      link_vld_q  <= link_vld_d;
    end
  end
`else
  logic unused_link_inputs;
  assign unused_link_inputs = ^{ll_i, st_i};
  assign sc_pass = llbit_i && (addr_i[1:0] == 2'b00);
`endif

  // Next state and next registered outputs of the SC handshake FSM.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = 1'b0;
    sc_done_d  = 1'b0;
    llbit_we_d = 1'b0;
    result_d   = result_q;
    flush_d    = flush_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle: begin
        flush_d = 1'b0;
        if (sc_go) begin
          if (sc_pass) begin
            state_d   = StWrite;
            mem_req_d = 1'b1;
            addr_d    = addr_i;
            wdata_d   = wdata_i;
          end else begin
            state_d    = StDone;
            sc_done_d  = 1'b1;
            llbit_we_d = 1'b1;
            result_d   = 1'b0;
          end
        end
      end
      StWrite: begin
        if (exc_flg_i) begin
          flush_d = 1'b1;
        end
        // The request is never withdrawn; a flush only hides the completion.
        if (mem_ack_i) begin
          state_d    = StDone;
          llbit_we_d = 1'b1;
          result_d   = 1'b1;
          sc_done_d  = !(flush_q || exc_flg_i);
        end else begin
          mem_req_d = 1'b1;
        end
      end
      StDone: begin
        state_d  = StIdle;
        result_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      sc_done_q  <= 1'b0;
      llbit_we_q <= 1'b0;
      result_q   <= 1'b0;
      flush_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      sc_done_q  <= sc_done_d;
      llbit_we_q <= llbit_we_d;
      result_q   <= result_d;
      flush_q    <= flush_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign llbit_we_o  = llbit_we_q;
  assign llbit_o     = 1'b0;
  // A flush arriving in the DONE cycle itself can only be honoured by masking.
  assign sc_done_o   = sc_done_q && !exc_flg_i;
  assign sc_result_o = {{(DATA_W-1){1'b0}}, result_q && sc_done_o};
  assign stall_o     = sc_go || (state_q == StWrite);

endmodule

// File: tb/tb_sc_resolver.sv
// Directed bench for sc_resolver; expectations follow the LINK_ADDR_CHECK_EN build.
module tb_sc_resolver;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              exc_flg_i, llbit_i, ll_i, sc_i, st_i, mem_ack_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              mem_req_o, stall_o, sc_done_o, llbit_we_o, llbit_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o, sc_result_o;

  int checks = 0;
  int errors = 0;

  sc_resolver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .exc_flg_i   (exc_flg_i),
    .llbit_i     (llbit_i),
    .ll_i        (ll_i),
    .sc_i        (sc_i),
    .st_i        (st_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .mem_ack_i   (mem_ack_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .stall_o     (stall_o),
    .sc_done_o   (sc_done_o),
    .sc_result_o (sc_result_o),
    .llbit_we_o  (llbit_we_o),
    .llbit_o     (llbit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; exc_flg_i = 1'b0; llbit_i = 1'b0; ll_i = 1'b0; sc_i = 1'b0;
    st_i = 1'b0; mem_ack_i = 1'b0; addr_i = '0; wdata_i = '0;
    step(); step();
    rst = 1'b0;
    settle();
    chk("rst_req", mem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_done", sc_done_o, 0);
    chk("rst_we", llbit_we_o, 0);
    chk("rst_llbit", llbit_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_result", sc_result_o, 0);

    // Ack outside WRITE is ignored.
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    settle();
    chk("idle_ack_req", mem_req_o, 0);
    chk("idle_ack_done", sc_done_o, 0);

    // LL then passing SC, ack on the third request cycle.
    ll_i = 1'b1; addr_i = 32'h1000;
    step();
    ll_i = 1'b0; sc_i = 1'b1; llbit_i = 1'b1; wdata_i = 32'hDEADBEEF;
    settle();
    chk("p_stall_idle", stall_o, 1);
    chk("p_req_idle", mem_req_o, 0);
    step();
    chk("p_req1", mem_req_o, 1);
    chk("p_addr1", mem_addr_o, 32'h1000);
    chk("p_data1", mem_wdata_o, 32'hDEADBEEF);
    chk("p_stall1", stall_o, 1);
    step();
    chk("p_req2", mem_req_o, 1);
    mem_ack_i = 1'b0;
    step();
    mem_ack_i = 1'b1;
    settle();
    chk("p_req3", mem_req_o, 1);
    chk("p_addr3", mem_addr_o, 32'h1000);
    chk("p_done3", sc_done_o, 0);
    step();
    mem_ack_i = 1'b0; sc_i = 1'b0;
    settle();
    chk("p_done", sc_done_o, 1);
    chk("p_result", sc_result_o, 1);
    chk("p_we", llbit_we_o, 1);
    chk("p_llbit", llbit_o, 0);
    chk("p_req_off", mem_req_o, 0);
    chk("p_stall_done", stall_o, 0);
    step();
    chk("p_done_off", sc_done_o, 0);
    chk("p_we_off", llbit_we_o, 0);

    // SC with atomic bit clear fails next cycle, no memory access.
    sc_i = 1'b1; llbit_i = 1'b0; addr_i = 32'h1000;
    settle();
    chk("f_stall", stall_o, 1);
    step();
    sc_i = 1'b0;
    settle();
    chk("f_done", sc_done_o, 1);
    chk("f_result", sc_result_o, 0);
    chk("f_req", mem_req_o, 0);
    chk("f_stall_done", stall_o, 0);
    chk("f_we", llbit_we_o, 1);
    step();

    // LL 0x2000, stores to 0x2004 then 0x2000, then SC 0x2000.
    ll_i = 1'b1; addr_i = 32'h2000;
    step();
    ll_i = 1'b0; st_i = 1'b1; addr_i = 32'h2004;
    step();
    addr_i = 32'h2000;
    step();
    st_i = 1'b0; sc_i = 1'b1; llbit_i = 1'b1;
    step();
`ifdef LINK_ADDR_CHECK_EN
    sc_i = 1'b0;
    settle();
    chk("snoop_done", sc_done_o, 1);
    chk("snoop_result", sc_result_o, 0);
    chk("snoop_req", mem_req_o, 0);
    step();
`else
    mem_ack_i = 1'b1;
    settle();
    chk("snoop_req", mem_req_o, 1);
    chk("snoop_addr", mem_addr_o, 32'h2000);
    step();
    mem_ack_i = 1'b0; sc_i = 1'b0;
    settle();
    chk("snoop_done", sc_done_o, 1);
    chk("snoop_result", sc_result_o, 1);
    step();
`endif

    // Misaligned SC fails without memory access.
    sc_i = 1'b1; llbit_i = 1'b1; addr_i = 32'h3002;
    step();
    sc_i = 1'b0;
    settle();
    chk("mis_done", sc_done_o, 1);
    chk("mis_result", sc_result_o, 0);
    chk("mis_req", mem_req_o, 0);
    step();

    // SC cancelled by a flush in IDLE.
    sc_i = 1'b1; exc_flg_i = 1'b1; llbit_i = 1'b1; addr_i = 32'h1000;
    settle();
    chk("cancel_stall", stall_o, 0);
    step();
    sc_i = 1'b0; exc_flg_i = 1'b0;
    settle();
    chk("cancel_done", sc_done_o, 0);
    chk("cancel_req", mem_req_o, 0);
    chk("cancel_we", llbit_we_o, 0);

    // Flush during WRITE: request held until ack, completion hidden.
    ll_i = 1'b1; addr_i = 32'h4000;
    step();
    ll_i = 1'b0; sc_i = 1'b1; llbit_i = 1'b1; wdata_i = 32'h1234_5678;
    step();
    exc_flg_i = 1'b1;
    settle();
    chk("x_req0", mem_req_o, 1);
    chk("x_stall0", stall_o, 1);
    step();
    exc_flg_i = 1'b0;
    settle();
    chk("x_req1", mem_req_o, 1);
    step();
    mem_ack_i = 1'b1;
    settle();
    chk("x_req2", mem_req_o, 1);
    chk("x_data2", mem_wdata_o, 32'h1234_5678);
    step();
    mem_ack_i = 1'b0; sc_i = 1'b0; llbit_i = 1'b0;
    settle();
    chk("x_done", sc_done_o, 0);
    chk("x_we", llbit_we_o, 1);
    chk("x_llbit", llbit_o, 0);
    chk("x_req_off", mem_req_o, 0);
    step();
    chk("x_we_off", llbit_we_o, 0);
    sc_i = 1'b1; addr_i = 32'h4000;
    step();
    sc_i = 1'b0;
    settle();
    chk("x_next_done", sc_done_o, 1);
    chk("x_next_result", sc_result_o, 0);
    step();

    // Reset in WRITE, then SC without a new LL fails.
    ll_i = 1'b1; addr_i = 32'h5000;
    step();
    ll_i = 1'b0; sc_i = 1'b1; llbit_i = 1'b1;
    step();
    chk("r_req_pre", mem_req_o, 1);
    rst = 1'b1; sc_i = 1'b0;
    step();
    rst = 1'b0;
    settle();
    chk("r_req", mem_req_o, 0);
    chk("r_addr", mem_addr_o, 0);
    chk("r_wdata", mem_wdata_o, 0);
    chk("r_stall", stall_o, 0);
    chk("r_done", sc_done_o, 0);
    chk("r_we", llbit_we_o, 0);
`ifdef LINK_ADDR_CHECK_EN
    llbit_i = 1'b1;
`else
    llbit_i = 1'b0;
`endif
    sc_i = 1'b1; addr_i = 32'h5000;
    step();
    sc_i = 1'b0;
    settle();
    chk("r_sc_done", sc_done_o, 1);
    chk("r_sc_result", sc_result_o, 0);
    chk("r_sc_req", mem_req_o, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
